pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: consecutive not-ready data-memory cycles tolerated before error.
REQ-002 One clock; reset is synchronous and active-high. Ports: i_clk in 1 (clock, rising edge), i_rst in 1 (synchronous, active-high reset).
REQ-003 i_rs1D, i_rs2D in 5: Decode-stage source registers.
REQ-004 i_rs1E, i_rs2E, i_rdE in 5: Execute-stage sources and destination.
REQ-005 i_ResultSrcE in 2: Execute result source; 2'b01 = load.
REQ-006 i_PCSrcE in 1: taken branch or jump resolved in Execute.
REQ-007 i_rdM in 5, i_RegWriteM in 1: Memory-stage destination and write enable.
REQ-008 i_rdW in 5, i_RegWriteW in 1: Writeback-stage destination and write enable.
REQ-009 i_MemReqM in 1: Memory stage holds a load or store.
REQ-010 i_dmem_ready in 1: data memory completes the current access this cycle.
REQ-011 o_dmem_req out 1: data-memory request strobe.
REQ-012 o_StallF, o_StallD, o_StallE, o_StallM out 1: hold the Fetch, Decode, Execute and Memory pipeline registers.
REQ-013 o_FlushD, o_FlushE, o_FlushW out 1: bubble the Decode, Execute and Writeback registers.
REQ-014 o_ForwardAE, o_ForwardBE out 2: ALU operand selects; 00 = register file, 01 = Writeback result, 10 = Memory result.
REQ-015 o_mem_timeout out 1: sticky data-memory timeout error.

Function
REQ-016 States: RUN, WAIT, ERROR.
REQ-017 o_dmem_req = i_MemReqM in RUN and WAIT; o_dmem_req = 0 in ERROR.
REQ-018 memStall = o_dmem_req & ~i_dmem_ready, combinational. A zero-wait access (ready high in the same cycle as req) causes no stall.
REQ-019 RUN->WAIT when memStall = 1.
REQ-020 WAIT->RUN in the cycle after i_dmem_ready = 1; the stall releases combinationally in the ready cycle.
REQ-021 Wait counter: reset to 0 in RUN; incremented each memStall cycle in WAIT.
REQ-022 WAIT->ERROR when the MEM_TIMEOUT-th consecutive memStall cycle completes; o_mem_timeout = 1 from the next cycle.
REQ-023 ERROR is exited only by i_rst.
REQ-024 lwStall = (i_ResultSrcE == 01) & (i_rdE != 0) & (i_rdE == i_rs1D | i_rdE == i_rs2D).
REQ-025 With memStall = 1 or state ERROR: o_StallF, o_StallD, o_StallE and o_StallM = 1; o_FlushW = 1; o_FlushD = 0; o_FlushE = 0. This memory stall dominates lwStall and i_PCSrcE, and the held branch re-evaluates after release.
REQ-026 Otherwise: o_StallF = o_StallD = lwStall; o_StallE = o_StallM = 0; o_FlushD = i_PCSrcE; o_FlushE = lwStall | i_PCSrcE; o_FlushW = 0.
REQ-027 lwStall and i_PCSrcE in the same cycle: stall F/D and flush D/E; the flush wins for D.
REQ-028 ForwardAE = 10 if i_RegWriteM & i_rdM != 0 & i_rdM == i_rs1E.
REQ-029 Else ForwardAE = 01 if i_RegWriteW & i_rdW != 0 & i_rdW == i_rs1E; else 00. ForwardBE uses the same rules with i_rs2E. The Memory match has priority over the Writeback match.
REQ-030 Forward selects are purely combinational and are not gated by stalls.

Reset
REQ-031 While i_rst = 1: state = RUN, counter = 0, o_mem_timeout = 0, o_dmem_req = 0, all stalls = 0, o_FlushD = o_FlushE = o_FlushW = 1.
REQ-032 The first cycle after reset deassertion behaves as RUN with counter 0.
REQ-033 i_rst asserted in WAIT or ERROR takes effect at the next rising edge, regardless of i_dmem_ready.

Structure
REQ-034 Shared package pipeline_pkg holds: the state enum; FWD_RF/FWD_WB/FWD_MEM constants; RES_SRC_ALU/MEM/PC4 constants, shared with the decoder.
REQ-035 Sub-module fwd_sel (combinational single-operand forward select), instantiated twice, for A and B.
REQ-036 State register and counter live in a single clocked process; all stall/flush logic is combinational.

Verification
REQ-037 Load-use hazard: i_ResultSrcE = 01, i_rdE = 5, i_rs1D = 5 -> StallF = StallD = FlushE = 1 for one cycle; with i_rdE = 0 -> no stall.
REQ-038 Forward priority: i_rdM = i_rdW = i_rs1E = 7, both writes enabled -> ForwardAE = 10; clear i_RegWriteM -> 01; set i_rs1E = 0 -> 00.
REQ-039 Memory wait: i_MemReqM = 1, ready low for 3 cycles then high -> all stalls and FlushW high for 3 cycles, released in the ready cycle, state returns to RUN; zero-wait ready -> no stall.
REQ-040 Branch during memory wait: i_PCSrcE = 1 with memStall -> FlushD = FlushE = 0 until ready; the next cycle -> FlushD = FlushE = 1.
REQ-041 Timeout: ready held low, MEM_TIMEOUT = 16 -> o_mem_timeout rises after 16 stall cycles, o_dmem_req drops, stalls persist; i_rst clears everything the next edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: controller state, forward selects and result
// source codes used by both the hazard controller and the decoder.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ERROR = 2'b10
  } pipe_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_SRC_ALU = 2'b00;
  localparam logic [1:0] RES_SRC_MEM = 2'b01;
  localparam logic [1:0] RES_SRC_PC4 = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: pipeline stage info in, stall/flush/forward out.
// Data memory: o_dmem_req is a request strobe; an access completes in any
// cycle where o_dmem_req and i_dmem_ready are both high, ready may be high in
// the request cycle, and req stays up while the Memory stage is held.
interface pipeline_ctrl_if;
  import pipeline_pkg::*;

  logic [4:0]  i_rs1D, i_rs2D;
  logic [4:0]  i_rs1E, i_rs2E, i_rdE;
  logic [1:0]  i_ResultSrcE;
  logic        i_PCSrcE;
  logic [4:0]  i_rdM, i_rdW;
  logic        i_RegWriteM, i_RegWriteW;
  logic        i_MemReqM;
  logic        i_dmem_ready;
  logic        o_dmem_req;
  logic        o_StallF, o_StallD, o_StallE, o_StallM;
  logic        o_FlushD, o_FlushE, o_FlushW;
  logic [1:0]  o_ForwardAE, o_ForwardBE;
  logic        o_mem_timeout;
  pipe_state_e o_state;

  modport master (
    output i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_ResultSrcE, i_PCSrcE,
           i_rdM, i_rdW, i_RegWriteM, i_RegWriteW, i_MemReqM, i_dmem_ready,
    input  o_dmem_req, o_StallF, o_StallD, o_StallE, o_StallM,
           o_FlushD, o_FlushE, o_FlushW, o_ForwardAE, o_ForwardBE,
           o_mem_timeout, o_state
  );

  modport slave (
    input  i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_ResultSrcE, i_PCSrcE,
           i_rdM, i_rdW, i_RegWriteM, i_RegWriteW, i_MemReqM, i_dmem_ready,
    output o_dmem_req, o_StallF, o_StallD, o_StallE, o_StallM,
           o_FlushD, o_FlushE, o_FlushW, o_ForwardAE, o_ForwardBE,
           o_mem_timeout, o_state
  );

endinterface

// File: rtl/pipeline_ctrl_fwd_sel.sv
// Single-operand ALU forward select; the Memory-stage result is newer than
// Writeback, so it wins when both match.
module fwd_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_mem,
  input  logic       reg_write_mem,
  input  logic [4:0] rd_wb,
  input  logic       reg_write_wb,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rs))
      fwd = FWD_MEM;
    else if (reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush,
// operand forwarding and data-memory wait handling with a sticky timeout.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16  // must be >= 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  pipeline_ctrl_if.slave  bus
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  // The first stall cycle is spent in RUN, so WAIT counts the remaining ones.
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_TIMEOUT - 2);

  pipe_state_e   state, state_next;
  logic [CW-1:0] wait_cnt, cnt_next;
  logic          dmem_req, mem_stall, lw_stall;

  assign dmem_req  = !i_rst && (state != ST_ERROR) && bus.i_MemReqM;
  assign mem_stall = dmem_req && !bus.i_dmem_ready;
  assign lw_stall  = (bus.i_ResultSrcE == RES_SRC_MEM) && (bus.i_rdE != 5'd0) &&
                     ((bus.i_rdE == bus.i_rs1D) || (bus.i_rdE == bus.i_rs2D));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    unique case (state)
      ST_RUN: begin
        cnt_next = '0;
        if (mem_stall) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_stall) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else if (wait_cnt == LAST_CNT) begin
          state_next = ST_ERROR;
        end else begin
          cnt_next = wait_cnt + 1'b1;
        end
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_RUN;
    endcase
  end

  // A held Memory stage freezes everything and must not drop the branch
  // flush, so the flush is deferred until the access releases.
  always_comb begin
    bus.o_StallF = 1'b0;
    bus.o_StallD = 1'b0;
    bus.o_StallE = 1'b0;
    bus.o_StallM = 1'b0;
    bus.o_FlushD = 1'b0;
    bus.o_FlushE = 1'b0;
    bus.o_FlushW = 1'b0;
    if (i_rst) begin
      bus.o_FlushD = 1'b1;
      bus.o_FlushE = 1'b1;
      bus.o_FlushW = 1'b1;
    end else if (mem_stall || (state == ST_ERROR)) begin
      bus.o_StallF = 1'b1;
      bus.o_StallD = 1'b1;
      bus.o_StallE = 1'b1;
      bus.o_StallM = 1'b1;
      bus.o_FlushW = 1'b1;
    end else begin
      bus.o_StallF = lw_stall;
      bus.o_StallD = lw_stall;
      bus.o_FlushD = bus.i_PCSrcE;
      bus.o_FlushE = lw_stall || bus.i_PCSrcE;
    end
  end

  assign bus.o_dmem_req    = dmem_req;
  assign bus.o_mem_timeout = (state == ST_ERROR) && !i_rst;
  assign bus.o_state       = state;

  fwd_sel u_fwd_a (
    .rs            (bus.i_rs1E),
    .rd_mem        (bus.i_rdM),
    .reg_write_mem (bus.i_RegWriteM),
    .rd_wb         (bus.i_rdW),
    .reg_write_wb  (bus.i_RegWriteW),
    .fwd           (bus.o_ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs            (bus.i_rs2E),
    .rd_mem        (bus.i_rdM),
    .reg_write_mem (bus.i_RegWriteM),
    .rd_wb         (bus.i_rdW),
    .reg_write_wb  (bus.i_RegWriteW),
    .fwd           (bus.o_ForwardBE)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios then random traffic,
// each cycle compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // model state: length of the current run of stalled memory cycles, error flag
  int   run_len = 0;
  bit   err     = 1'b0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic wm, input logic [4:0] rdw,
                                         input logic ww);
    if (wm && rdm != 0 && rdm == rs) return 2'b10;
    if (ww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    bus.i_rs1D = 0; bus.i_rs2D = 0; bus.i_rs1E = 0; bus.i_rs2E = 0; bus.i_rdE = 0;
    bus.i_ResultSrcE = 2'b00; bus.i_PCSrcE = 0;
    bus.i_rdM = 0; bus.i_rdW = 0; bus.i_RegWriteM = 0; bus.i_RegWriteW = 0;
    bus.i_MemReqM = 0; bus.i_dmem_ready = 0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    logic e_req, e_ms, hold, lw;
    logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    pipe_state_e e_state;
    @(negedge clk);
    e_req = !rst && !err && bus.i_MemReqM;
    e_ms  = e_req && !bus.i_dmem_ready;
    hold  = !rst && (e_ms || err);
    lw    = (bus.i_ResultSrcE == 2'b01) && (bus.i_rdE != 0) &&
            ((bus.i_rdE == bus.i_rs1D) || (bus.i_rdE == bus.i_rs2D));
    if (rst) begin
      {e_sf, e_sd, e_se, e_sm} = 4'b0000; {e_fd, e_fe, e_fw} = 3'b111;
    end else if (hold) begin
      {e_sf, e_sd, e_se, e_sm} = 4'b1111; {e_fd, e_fe, e_fw} = 3'b001;
    end else begin
      e_sf = lw; e_sd = lw; e_se = 0; e_sm = 0;
      e_fd = bus.i_PCSrcE; e_fe = lw | bus.i_PCSrcE; e_fw = 0;
    end
    e_state = err ? ST_ERROR : ((run_len > 0) ? ST_WAIT : ST_RUN);
    check("dmem_req", 32'(bus.o_dmem_req), 32'(e_req));
    check("StallF",   32'(bus.o_StallF),   32'(e_sf));
    check("StallD",   32'(bus.o_StallD),   32'(e_sd));
    check("StallE",   32'(bus.o_StallE),   32'(e_se));
    check("StallM",   32'(bus.o_StallM),   32'(e_sm));
    check("FlushD",   32'(bus.o_FlushD),   32'(e_fd));
    check("FlushE",   32'(bus.o_FlushE),   32'(e_fe));
    check("FlushW",   32'(bus.o_FlushW),   32'(e_fw));
    check("ForwardAE", 32'(bus.o_ForwardAE),
          32'(fwd_ref(bus.i_rs1E, bus.i_rdM, bus.i_RegWriteM, bus.i_rdW, bus.i_RegWriteW)));
    check("ForwardBE", 32'(bus.o_ForwardBE),
          32'(fwd_ref(bus.i_rs2E, bus.i_rdM, bus.i_RegWriteM, bus.i_rdW, bus.i_RegWriteW)));
    check("mem_timeout", 32'(bus.o_mem_timeout), 32'(err && !rst));
    check("state", 32'(bus.o_state), 32'(e_state));
    @(posedge clk);
    if (rst) begin
      err = 0; run_len = 0;
    end else if (!err) begin
      if (e_ms) begin
        run_len++;
        if (run_len >= MEM_TIMEOUT) err = 1;
      end else begin
        run_len = 0;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) cycle();
    rst = 0;
    cycle();

    // load-use hazard, then the same with x0 as destination
    bus.i_ResultSrcE = 2'b01; bus.i_rdE = 5; bus.i_rs1D = 5;
    cycle();
    bus.i_rdE = 0; bus.i_rs1D = 0;
    cycle();
    idle();

    // forwarding priority on both operands
    bus.i_RegWriteM = 1; bus.i_RegWriteW = 1;
    bus.i_rdM = 7; bus.i_rdW = 7; bus.i_rs1E = 7; bus.i_rs2E = 7;
    cycle();
    bus.i_RegWriteM = 0;
    cycle();
    bus.i_rs1E = 0;
    cycle();
    idle();

    // three-cycle memory wait, release, then zero-wait access
    bus.i_MemReqM = 1; bus.i_dmem_ready = 0;
    repeat (3) cycle();
    bus.i_dmem_ready = 1;
    cycle();
    bus.i_MemReqM = 0;
    cycle();
    bus.i_MemReqM = 1; bus.i_dmem_ready = 1;
    repeat (2) cycle();
    idle();

    // branch held under a memory wait, flushed after release
    bus.i_PCSrcE = 1; bus.i_MemReqM = 1; bus.i_dmem_ready = 0;
    repeat (2) cycle();
    bus.i_dmem_ready = 1;
    cycle();
    bus.i_MemReqM = 0;
    cycle();
    idle();

    // load-use and branch together
    bus.i_ResultSrcE = 2'b01; bus.i_rdE = 3; bus.i_rs2D = 3; bus.i_PCSrcE = 1;
    cycle();
    idle();

    // timeout: ready never comes, then reset recovers
    bus.i_MemReqM = 1; bus.i_dmem_ready = 0;
    repeat (MEM_TIMEOUT + 4) cycle();
    bus.i_dmem_ready = 1;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    repeat (2) cycle();
    idle();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.i_rs1D = 5'($urandom_range(0, 3));
      bus.i_rs2D = 5'($urandom_range(0, 3));
      bus.i_rs1E = 5'($urandom_range(0, 3));
      bus.i_rs2E = 5'($urandom_range(0, 3));
      bus.i_rdE  = 5'($urandom_range(0, 3));
      bus.i_rdM  = 5'($urandom_range(0, 3));
      bus.i_rdW  = 5'($urandom_range(0, 3));
      bus.i_ResultSrcE = 2'($urandom_range(0, 3));
      bus.i_PCSrcE     = ($urandom_range(0, 3) == 0);
      bus.i_RegWriteM  = 1'($urandom_range(0, 1));
      bus.i_RegWriteW  = 1'($urandom_range(0, 1));
      bus.i_MemReqM    = ($urandom_range(0, 3) != 0);
      bus.i_dmem_ready = (i % 400 > 370) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rst              = ($urandom_range(0, 99) == 0) || (i % 400 == 399);
      cycle();
    end
    rst = 0;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
